// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  // Host side: supplies the stream and observes the memory writes.
  modport master (
    output byte_in, byte_valid,
    input  byte_ready, we, waddr, wdata
  );

  // Loader side.
  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a checksummed big-endian byte stream into instruction
// memory words and holds the core in reset until the image is verified.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         done,
  output logic         error
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned IDX_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, DATA, WRITE, CHK, RUN, ERR
  } state_e;

  state_e            state_q;
  logic [15:0]       n_q;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        bcnt_q;
  logic [7:0]        chk_q;
  logic [23:0]       asm_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              core_rst_q;
  logic              done_q;
  logic              error_q;

  logic              ready;
  logic              accept;
  logic [15:0]       n_full;
  logic              last_word;

  // Ready is decoded from state so the WRITE cycle naturally stalls the stream.
  always_comb begin
    ready     = 1'b0;
    if (rst) begin
      ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
              (state_q == DATA)   || (state_q == CHK);
    end
    accept    = bus.byte_valid && ready;
    n_full    = {n_q[15:8], bus.byte_in};
    last_word = (16'(idx_q) == (n_q - 16'd1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HDR_HI;
      n_q        <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      chk_q      <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        HDR_HI: begin
          if (accept) begin
            n_q[15:8] <= bus.byte_in;
            state_q   <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            n_q[7:0] <= bus.byte_in;
            if (n_full > 16'(DEPTH)) begin
              state_q <= ERR;
              error_q <= 1'b1;
            end else if (n_full == 16'd0) begin
              state_q <= CHK;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            chk_q  <= chk_q ^ bus.byte_in;
            asm_q  <= {asm_q[15:0], bus.byte_in};
            bcnt_q <= bcnt_q + 2'd1;
            // Fourth byte completes the word; present it during the WRITE cycle.
            if (bcnt_q == 2'd3) begin
              state_q <= WRITE;
              we_q    <= 1'b1;
              waddr_q <= idx_q[ADDR_W-1:0];
              wdata_q <= {asm_q, bus.byte_in};
            end
          end
        end
        WRITE: begin
          if (last_word) begin
            state_q <= CHK;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= DATA;
          end
        end
        CHK: begin
          if (accept) begin
            if (bus.byte_in == chk_q) begin
              state_q    <= RUN;
              done_q     <= 1'b1;
              core_rst_q <= 1'b1;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        RUN: state_q <= RUN;
        ERR: state_q <= ERR;
        default: begin
          state_q <= ERR;
          error_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready = ready;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign core_rst       = core_rst_q;
  assign done           = done_q;
  assign error          = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  logic clk;
  logic rst;
  logic core_rst, done, error;

  imem_loader_if #(.ADDR_W(8)) bus_if ();

  imem_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record every write strobe; the stream must be stalled while it is high.
  always @(negedge clk) begin
    if (rst && bus_if.we) begin
      wr_addr.push_back(bus_if.waddr);
      wr_data.push_back(bus_if.wdata);
      check("ready_in_write", 32'(bus_if.byte_ready), 32'd0);
    end
    if (rst && done && error) check("done_and_error", 32'd1, 32'd0);
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus_if.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus_if.byte_in    = b;
    bus_if.byte_valid = 1'b1;
    n = 0;
    while (!bus_if.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.byte_ready) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    bus_if.byte_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic do_reset();
    bus_if.byte_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    check("rst_we", 32'(bus_if.we), 32'd0);
    check("rst_waddr", 32'(bus_if.waddr), 32'd0);
    check("rst_wdata", bus_if.wdata, 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(bus_if.byte_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_single(input logic [7:0] chk);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0); send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0);
    send_byte(chk, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    bus_if.byte_in    = 8'h00;
    bus_if.byte_valid = 1'b0;
    @(negedge clk);

    // Single word
    do_reset();
    check("ready_after_rst", 32'(bus_if.byte_ready), 32'd1);
    send_single(8'h2D);
    check("s_done", 32'(done), 32'd1);
    check("s_core_rst", 32'(core_rst), 32'd1);
    check("s_error", 32'(error), 32'd0);
    check("s_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("s_waddr", 32'(wr_addr[0]), 32'd0);
      check("s_wdata", wr_data[0], 32'h20080005);
    end
    bus_if.byte_valid = 1'b1;
    @(negedge clk);
    check("s_ready_run", 32'(bus_if.byte_ready), 32'd0);
    idle(2);
    check("s_we_idle", 32'(bus_if.we), 32'd0);

    // Two words with gaps between bytes
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h09, 1'b1);
    send_byte(8'h50, 1'b1); send_byte(8'h20, 1'b1);
    send_byte(8'hAC, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hDE, 1'b1);
    idle(1);
    check("t_done", 32'(done), 32'd1);
    check("t_error", 32'(error), 32'd0);
    check("t_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t_waddr0", 32'(wr_addr[0]), 32'd0);
      check("t_wdata0", wr_data[0], 32'h01095020);
      check("t_waddr1", 32'(wr_addr[1]), 32'd1);
      check("t_wdata1", wr_data[1], 32'hAC0A0000);
    end

    // Bad checksum
    do_reset();
    send_single(8'h2C);
    check("b_error", 32'(error), 32'd1);
    check("b_done", 32'(done), 32'd0);
    check("b_core_rst", 32'(core_rst), 32'd0);
    check("b_nwr", 32'(wr_addr.size()), 32'd1);
    bus_if.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("b_ready", 32'(bus_if.byte_ready), 32'd0);
    check("b_error_sticky", 32'(error), 32'd1);
    idle(1);

    // Oversize header
    do_reset();
    send_byte(8'h01, 1'b0);
    check("o_error_early", 32'(error), 32'd0);
    send_byte(8'h01, 1'b0);
    check("o_error", 32'(error), 32'd1);
    check("o_ready", 32'(bus_if.byte_ready), 32'd0);
    idle(3);
    check("o_nwr", 32'(wr_addr.size()), 32'd0);
    check("o_done", 32'(done), 32'd0);

    // Zero-length image
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    check("z_done_early", 32'(done), 32'd0);
    send_byte(8'h00, 1'b0);
    idle(2);
    check("z_done", 32'(done), 32'd1);
    check("z_core_rst", 32'(core_rst), 32'd1);
    check("z_nwr", 32'(wr_addr.size()), 32'd0);

    // Full depth: word i = {i, i^3C, 11, i+1}
    do_reset();
    begin
      logic [7:0]  x;
      logic [31:0] w;
      logic [7:0]  ck;
      ck = 8'h00;
      send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
      for (int i = 0; i < 256; i++) begin
        x = 8'(i);
        w = {x, x ^ 8'h3C, 8'h11, x + 8'd1};
        ck = ck ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        send_byte(w[31:24], 1'b0); send_byte(w[23:16], 1'b0);
        send_byte(w[15:8], 1'b0);  send_byte(w[7:0], 1'b0);
      end
      send_byte(ck, 1'b0);
      idle(1);
      check("f_done", 32'(done), 32'd1);
      check("f_error", 32'(error), 32'd0);
      check("f_nwr", 32'(wr_addr.size()), 32'd256);
      if (wr_addr.size() == 256) begin
        check("f_last_waddr", 32'(wr_addr[255]), 32'h000000FF);
        for (int i = 0; i < 256; i++) begin
          x = 8'(i);
          w = {x, x ^ 8'h3C, 8'h11, x + 8'd1};
          check("f_waddr", 32'(wr_addr[i]), 32'(i));
          check("f_wdata", wr_data[i], w);
        end
      end
    end

    // Reset in the middle of a load, then a fresh image
    do_reset();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0); send_byte(8'h08, 1'b0);
    do_reset();
    send_single(8'h2D);
    check("m_done", 32'(done), 32'd1);
    check("m_error", 32'(error), 32'd0);
    check("m_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("m_waddr", 32'(wr_addr[0]), 32'd0);
      check("m_wdata", wr_data[0], 32'h20080005);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
